frame_unpack: RTL and testbench

- Downstream consumer of the 128-bit serial_buff word.
- Accepts a full parallel frame on a valid strobe and checks the sync header and length field.
- Emits payload bytes one at a time over a valid/ready byte stream, then reports frame status.
- Sits between serial_buff and the byte-level packet logic.

---
 rtl/frame_unpack_if.sv | 26 ++
 rtl/frame_unpack.sv | 153 +++++++++++++++
 tb/tb_frame_unpack.sv | 326 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/frame_unpack_if.sv
// frame_unpack_if: frame input, payload byte stream and status pulses of frame_unpack.
// master = the side feeding frames and consuming bytes; slave = frame_unpack.
interface frame_unpack_if #(
  parameter int NDATA = 128
);
  logic [NDATA-1:0] din;
  logic             dvalid;
  logic             dready;
  logic [7:0]       dout;
  logic             ovalid;
  logic             oready;
  logic             fdone;
  logic             fok;
  logic             err;
  logic             drop;

  modport master (
    output din, dvalid, oready,
    input  dready, dout, ovalid, fdone, fok, err, drop
  );

  modport slave (
    input  din, dvalid, oready,
    output dready, dout, ovalid, fdone, fok, err, drop
  );
endinterface

// File: rtl/frame_unpack.sv
// frame_unpack: latches one parallel frame, checks sync header and length,
// streams payload bytes over valid/ready, then pulses fdone/fok or err.
// Optional CRC-8 check (poly 0x07, init 0, MSB-first) over header, L and
// payload is built only when FRAME_UNPACK_CRC_EN is defined; otherwise fok=1.
module frame_unpack #(
  parameter int         NDATA  = 128,
  parameter logic [7:0] SYNC   = 8'hA5,
  parameter int         MAXLEN = NDATA/8 - 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ena,
  frame_unpack_if.slave bus
);

  localparam int             NBYTE = NDATA / 8;
  localparam int             IW    = $clog2(NBYTE);
  localparam logic [IW-1:0]  TOPB  = IW'(NBYTE - 1);
  localparam logic [7:0]     MAXL8 = 8'(MAXLEN);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_EMIT,
    S_FIN,
    S_ERR
  } state_t;

  state_t                  state_q;
  logic [NBYTE-1:0][7:0]   frame_q;   // byte i of the frame sits at frame_q[NBYTE-1-i]
  logic [IW-1:0]           idx_q;     // index of the byte currently on dout
  logic [IW-1:0]           last_q;    // index of the final payload byte (L+1)
  logic [7:0]              dout_q;
  logic                    ovalid_q;
  logic                    fdone_q;
  logic                    fok_q;
  logic                    err_q;
  logic                    drop_q;

  logic [7:0]              hdr;
  logic [7:0]              len;
  logic                    len_bad;
  logic [IW-1:0]           idx_nx;
  logic [7:0]              byte_nx;
  logic                    crc_chk_ok;  // L==0 frame: CRC over header+L matches byte 2
  logic                    crc_end_ok;  // last payload byte taken: CRC matches byte L+2

  assign hdr     = frame_q[NBYTE-1];
  assign len     = frame_q[NBYTE-2];
  assign len_bad = (len > MAXL8);
  assign idx_nx  = idx_q + IW'(1);
  assign byte_nx = frame_q[TOPB - idx_nx];

`ifdef FRAME_UNPACK_CRC_EN
  logic [7:0] crc_q;
  logic [7:0] crc_hdr_d;
  logic [7:0] crc_take_d;

  function automatic logic [7:0] crc8_byte(input logic [7:0] c, input logic [7:0] b);
    logic [7:0] r;
    r = c ^ b;
    for (int k = 0; k < 8; k++) r = r[7] ? ((r << 1) ^ 8'h07) : (r << 1);
    return r;
  endfunction

  assign crc_hdr_d  = crc8_byte(crc8_byte(8'h00, hdr), len);
  assign crc_take_d = crc8_byte(crc_q, dout_q);
  assign crc_chk_ok = (crc_hdr_d == frame_q[NBYTE-3]);
  assign crc_end_ok = (crc_take_d == frame_q[TOPB - last_q - IW'(1)]);

  // CRC register: header and L during CHECK, then each payload byte as it is taken
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      crc_q <= '0;
    end else if (ena) begin
      if (state_q == S_CHECK)                               crc_q <= crc_hdr_d;
      else if (state_q == S_EMIT && ovalid_q && bus.oready) crc_q <= crc_take_d;
    end
  end
`else
  assign crc_chk_ok = 1'b1;
  assign crc_end_ok = 1'b1;
`endif

  // Frame FSM with registered stream and status outputs; ena=0 freezes everything
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      frame_q  <= '0;
      idx_q    <= '0;
      last_q   <= '0;
      dout_q   <= '0;
      ovalid_q <= 1'b0;
      fdone_q  <= 1'b0;
      fok_q    <= 1'b0;
      err_q    <= 1'b0;
      drop_q   <= 1'b0;
    end else if (ena) begin
      drop_q  <= bus.dvalid && (state_q != S_IDLE);
      fdone_q <= 1'b0;
      err_q   <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (bus.dvalid) begin
            frame_q <= bus.din;
            state_q <= S_CHECK;
          end
        end
        S_CHECK: begin
          if (hdr != SYNC || len_bad) begin
            err_q   <= 1'b1;
            state_q <= S_ERR;
          end else if (len == 8'h00) begin
            fdone_q <= 1'b1;
            fok_q   <= crc_chk_ok;
            state_q <= S_FIN;
          end else begin
            idx_q    <= IW'(2);
            last_q   <= IW'(len) + IW'(1);
            dout_q   <= frame_q[TOPB - IW'(2)];
            ovalid_q <= 1'b1;
            state_q  <= S_EMIT;
          end
        end
        S_EMIT: begin
          // ovalid_q is high for the whole of EMIT, so oready alone completes a transfer
          if (bus.oready) begin
            if (idx_q == last_q) begin
              ovalid_q <= 1'b0;
              fdone_q  <= 1'b1;
              fok_q    <= crc_end_ok;
              state_q  <= S_FIN;
            end else begin
              idx_q  <= idx_nx;
              dout_q <= byte_nx;
            end
          end
        end
        S_FIN, S_ERR: state_q <= S_IDLE;
        default:      state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.dready = (state_q == S_IDLE) && ena;
  assign bus.dout   = dout_q;
  assign bus.ovalid = ovalid_q;
  assign bus.fdone  = fdone_q;
  assign bus.fok    = fok_q;
  assign bus.err    = err_q;
  assign bus.drop   = drop_q;

endmodule

// File: tb/tb_frame_unpack.sv
// tb_frame_unpack: directed frames with literal expectations plus a random
// phase, all checked every cycle against a step-queue model of the frame flow.
module tb_frame_unpack;
  localparam int NDATA = 128;
  localparam int NBYTE = NDATA / 8;

  localparam logic [1:0] K_CHK  = 2'd0;
  localparam logic [1:0] K_BYTE = 2'd1;
  localparam logic [1:0] K_DONE = 2'd2;
  localparam logic [1:0] K_ERR  = 2'd3;

`ifdef FRAME_UNPACK_CRC_EN
  localparam logic BAD_CRC_FOK = 1'b0;
`else
  localparam logic BAD_CRC_FOK = 1'b1;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic ena = 1'b0;

  frame_unpack_if #(.NDATA(NDATA)) bus ();

  frame_unpack #(.NDATA(NDATA)) dut (
    .clk (clk),
    .rst (rst),
    .ena (ena),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  int nvec = 0;
  int nerr = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] crc8(input logic [7:0] c, input logic [7:0] b);
    logic [7:0] r;
    r = c ^ b;
    for (int k = 0; k < 8; k++) r = r[7] ? ((r << 1) ^ 8'h07) : (r << 1);
    return r;
  endfunction

  // ---------------- model: each accepted frame becomes a list of steps ----------------
  typedef struct {
    logic [1:0] kind;
    logic [7:0] val;
  } step_t;

  step_t sq[$];
  logic  m_drop;

  task automatic build(input logic [NDATA-1:0] f);
    logic [7:0] b[NBYTE];
    logic [7:0] c;
    int         l;
    for (int i = 0; i < NBYTE; i++) b[i] = f[NDATA-1-8*i -: 8];
    sq.push_back('{K_CHK, 8'h00});
    if (b[0] != 8'hA5 || b[1] > 8'd13) begin
      sq.push_back('{K_ERR, 8'h00});
    end else begin
      l = int'(b[1]);
      c = crc8(crc8(8'h00, b[0]), b[1]);
      for (int p = 2; p <= l + 1; p++) begin
        sq.push_back('{K_BYTE, b[p]});
        c = crc8(c, b[p]);
      end
`ifdef FRAME_UNPACK_CRC_EN
      sq.push_back('{K_DONE, {7'd0, c == b[l+2]}});
`else
      sq.push_back('{K_DONE, 8'h01});
`endif
    end
  endtask

  always @(posedge clk or negedge rst) begin
    bit was_idle;
    if (!rst) begin
      sq.delete();
      m_drop = 1'b0;
    end else if (ena) begin
      was_idle = (sq.size() == 0);
      m_drop   = bus.dvalid && !was_idle;
      if (!was_idle) begin
        if (sq[0].kind != K_BYTE || bus.oready) void'(sq.pop_front());
      end else if (bus.dvalid) begin
        build(bus.din);
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    step_t h;
    bit    has;
    has = (sq.size() > 0);
    h   = '{K_CHK, 8'h00};
    if (has) h = sq[0];
    chk("dready", bus.dready, ena && !has);
    chk("ovalid", bus.ovalid, has && h.kind == K_BYTE);
    if (has && h.kind == K_BYTE) chk("dout", bus.dout, h.val);
    chk("fdone", bus.fdone, has && h.kind == K_DONE);
    if (has && h.kind == K_DONE) chk("fok", bus.fok, h.val[0]);
    chk("err", bus.err, has && h.kind == K_ERR);
    chk("drop", bus.drop, m_drop);
    if (!rst) chk("dout_in_reset", bus.dout, 0);
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [NDATA-1:0] f);
    bus.din    = f;
    bus.dvalid = 1'b1;
    step();
    bus.dvalid = 1'b0;
  endtask

  function automatic logic [NDATA-1:0] mk_frame(input logic [7:0] h, input logic [7:0] l,
                                                input logic [7:0] p0, input logic [7:0] p1,
                                                input logic [7:0] p2);
    logic [NDATA-1:0] f;
    logic [7:0]       c;
    f = '0;
    f[NDATA-1 -: 40] = {h, l, p0, p1, p2};
    c = crc8(crc8(crc8(crc8(crc8(8'h00, h), l), p0), p1), p2);
    f[NDATA-41 -: 8] = c;
    return f;
  endfunction

  function automatic logic [NDATA-1:0] rand_frame();
    logic [NDATA-1:0] f;
    logic [7:0]       c;
    int               l;
    for (int i = 0; i < NBYTE; i++) f[NDATA-1-8*i -: 8] = 8'($urandom);
    f[NDATA-1 -: 8] = ($urandom_range(0, 9) < 8) ? 8'hA5 : 8'($urandom);
    l = $urandom_range(0, 15);
    f[NDATA-9 -: 8] = 8'(l);
    if (l <= 13 && $urandom_range(0, 3) != 0) begin
      c = 8'h00;
      for (int i = 0; i <= l + 1; i++) c = crc8(c, f[NDATA-1-8*i -: 8]);
      f[NDATA-1-8*(l+2) -: 8] = c;
    end
    return f;
  endfunction

  logic [NDATA-1:0] f_good, f_badcrc, f_badhdr, f_badlen, f_three;

  initial begin
    f_good   = 128'hA5013C29_00000000_00000000_00000000;
    f_badcrc = 128'hA5013C28_00000000_00000000_00000000;
    f_badhdr = 128'h5A013C29_00000000_00000000_00000000;
    f_badlen = 128'hA50E3C29_00000000_00000000_00000000;
    f_three  = mk_frame(8'hA5, 8'h03, 8'h11, 8'h22, 8'h33);

    bus.din    = '0;
    bus.dvalid = 1'b0;
    bus.oready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ovalid", bus.ovalid, 0);
    chk("rst_dout", bus.dout, 0);
    chk("rst_fdone", bus.fdone, 0);
    chk("rst_err", bus.err, 0);
    rst = 1'b1;
    ena = 1'b1;
    step();
    chk("dready_after_rst", bus.dready, 1);

    // good single-byte frame
    bus.oready = 1'b1;
    send(f_good);
    step();
    chk("good_ovalid", bus.ovalid, 1);
    chk("good_dout", bus.dout, 8'h3C);
    step();
    chk("good_fdone", bus.fdone, 1);
    chk("good_fok", bus.fok, 1);
    chk("good_err", bus.err, 0);
    step();
    chk("good_dready", bus.dready, 1);

    // corrupted CRC byte
    send(f_badcrc);
    step();
    chk("badcrc_dout", bus.dout, 8'h3C);
    step();
    chk("badcrc_fdone", bus.fdone, 1);
    chk("badcrc_fok", bus.fok, BAD_CRC_FOK);
    step();

    // bad header, then bad length
    send(f_badhdr);
    step();
    chk("badhdr_err", bus.err, 1);
    chk("badhdr_ovalid", bus.ovalid, 0);
    step();
    chk("badhdr_dready", bus.dready, 1);
    send(f_badlen);
    step();
    chk("badlen_err", bus.err, 1);
    chk("badlen_ovalid", bus.ovalid, 0);
    step();
    chk("badlen_dready", bus.dready, 1);

    // backpressure on the second byte
    send(f_three);
    step();
    chk("bp_b0", bus.dout, 8'h11);
    step();
    chk("bp_b1", bus.dout, 8'h22);
    bus.oready = 1'b0;
    repeat (4) begin
      step();
      chk("bp_hold", bus.dout, 8'h22);
      chk("bp_hold_v", bus.ovalid, 1);
    end
    bus.oready = 1'b1;
    step();
    chk("bp_b2", bus.dout, 8'h33);
    step();
    chk("bp_fdone", bus.fdone, 1);
    step();

    // full throughput
    send(f_three);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("tp_ovalid", bus.ovalid, 1);
    end
    step();
    chk("tp_fdone", bus.fdone, 1);
    step();

    // overrun while emitting
    bus.oready = 1'b0;
    send(f_three);
    step();
    bus.din    = f_badhdr;
    bus.dvalid = 1'b1;
    step();
    bus.dvalid = 1'b0;
    chk("ovr_drop", bus.drop, 1);
    chk("ovr_dout", bus.dout, 8'h11);
    bus.oready = 1'b1;
    step();
    chk("ovr_drop_clr", bus.drop, 0);
    chk("ovr_b1", bus.dout, 8'h22);
    step();
    step();
    chk("ovr_fdone", bus.fdone, 1);
    step();

    // clock enable low mid-frame
    send(f_three);
    step();
    step();
    ena        = 1'b0;
    bus.dvalid = 1'b1;
    repeat (5) begin
      step();
      chk("ena_dout", bus.dout, 8'h22);
      chk("ena_ovalid", bus.ovalid, 1);
      chk("ena_drop", bus.drop, 0);
    end
    ena        = 1'b1;
    bus.dvalid = 1'b0;
    step();
    chk("ena_b2", bus.dout, 8'h33);
    step();
    chk("ena_fdone", bus.fdone, 1);
    step();

    // asynchronous reset mid-frame
    bus.oready = 1'b0;
    send(f_three);
    step();
    #2 rst = 1'b0;
    #1;
    chk("arst_ovalid", bus.ovalid, 0);
    chk("arst_dout", bus.dout, 0);
    step();
    rst = 1'b1;
    chk("arst_dready", bus.dready, 1);
    bus.oready = 1'b1;
    send(f_good);
    step();
    chk("arst_next_dout", bus.dout, 8'h3C);
    step();
    chk("arst_next_fdone", bus.fdone, 1);
    step();

    // random traffic
    for (int n = 0; n < 3000; n++) begin
      ena        = ($urandom_range(0, 9) != 0);
      bus.oready = ($urandom_range(0, 3) != 0);
      bus.dvalid = ($urandom_range(0, 3) == 0);
      bus.din    = rand_frame();
      if ($urandom_range(0, 599) == 0) begin
        rst = 1'b0;
        step();
        rst = 1'b1;
      end
      step();
    end

    ena        = 1'b1;
    bus.dvalid = 1'b0;
    bus.oready = 1'b1;
    repeat (40) step();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
